// File: rtl/vpu_operand_fetch_ctrl_pkg.sv
// Shared types and default sizing for the VPU operand fetch controller.
package vpu_operand_fetch_ctrl_pkg;

  localparam int N_PORTS_DEF     = 3;
  localparam int OPCODE_W_DEF    = 8;
  localparam int BANK_LG2_DEF    = 5;
  localparam int DEPTH_LG2_DEF   = 10;
  localparam int DATA_W_DEF      = 512;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } fetch_state_t;

  // Operand address as carried on the request bus: bank id in the MSBs.
  typedef struct packed {
    logic [BANK_LG2_DEF-1:0]  bank;
    logic [DEPTH_LG2_DEF-1:0] row;
  } opnd_addr_t;

  // Width of a counter that must hold values 0..limit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/vpu_operand_fetch_ctrl_if.sv
// Request, SRAM-read and operand-bundle signals of the operand fetch controller.
// slave = the fetch controller, master = its environment (decoder/SRAM/ALU).
interface vpu_operand_fetch_ctrl_if #(
  parameter int N_PORTS   = 3,
  parameter int OPCODE_W  = 8,
  parameter int BANK_LG2  = 5,
  parameter int DEPTH_LG2 = 10,
  parameter int DATA_W    = 512
);
  localparam int ADDR_W = BANK_LG2 + DEPTH_LG2;

  logic                          in_valid;
  logic                          in_ready;
  logic [OPCODE_W-1:0]           in_opcode;
  logic [N_PORTS-1:0]            in_rmask;
  logic [N_PORTS*ADDR_W-1:0]     in_raddr;
  logic [ADDR_W-1:0]             in_waddr;

  logic [N_PORTS-1:0]            src_req;
  logic [N_PORTS-1:0]            src_ack;
  logic [N_PORTS*BANK_LG2-1:0]   src_rid;
  logic [N_PORTS*DEPTH_LG2-1:0]  src_addr;
  logic [N_PORTS-1:0]            src_reb;
  logic [N_PORTS-1:0]            src_rlast;
  logic [N_PORTS*DATA_W-1:0]     src_rdata;
  logic [N_PORTS-1:0]            src_rvalid;

  logic                          out_valid;
  logic                          out_ready;
  logic [OPCODE_W-1:0]           out_opcode;
  logic [ADDR_W-1:0]             out_waddr;
  logic [N_PORTS*DATA_W-1:0]     out_operand;

  logic                          busy;
  logic                          timeout_err;

  modport slave (
    input  in_valid, in_opcode, in_rmask, in_raddr, in_waddr,
    output in_ready,
    output src_req, src_rid, src_addr, src_reb, src_rlast,
    input  src_ack, src_rdata, src_rvalid,
    output out_valid, out_opcode, out_waddr, out_operand,
    input  out_ready,
    output busy, timeout_err
  );

  modport master (
    output in_valid, in_opcode, in_rmask, in_raddr, in_waddr,
    input  in_ready,
    input  src_req, src_rid, src_addr, src_reb, src_rlast,
    output src_ack, src_rdata, src_rvalid,
    input  out_valid, out_opcode, out_waddr, out_operand,
    output out_ready,
    input  busy, timeout_err
  );
endinterface

// File: rtl/vpu_operand_fetch_ctrl_slot.sv
// One SRAM read port of the fetch controller: request, outstanding and
// got flags plus the captured operand register.
module vpu_fetch_port_slot #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,      // new instruction accepted
  input  logic              load_req,  // this port's mask bit
  input  logic              clr,       // abandon flags (handshake or watchdog)
  input  logic              ack,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              req,
  output logic              outstanding,
  output logic              got,
  output logic [DATA_W-1:0] data
);

  // Per-port read sequencing: req until ack, then wait for one rvalid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      req         <= 1'b0;
      outstanding <= 1'b0;
      got         <= 1'b0;
      // NOTE: the operand register is a plain flop bank (not a RAM), so it is
      // reset; it must read as zero for ports that were never fetched.
      data        <= '0;
    end else if (load) begin
      req         <= load_req;
      outstanding <= 1'b0;
      got         <= 1'b0;
      data        <= '0;
    end else if (clr) begin
      req         <= 1'b0;
      outstanding <= 1'b0;
      got         <= 1'b0;
    end else if (req && ack) begin
      // An rvalid in the ack cycle itself is ignored: outstanding is not set yet.
      req         <= 1'b0;
      outstanding <= 1'b1;
    end else if (outstanding && rvalid) begin
      outstanding <= 1'b0;
      got         <= 1'b1;
      data        <= rdata;
    end
  end

endmodule

// File: rtl/vpu_operand_fetch_ctrl.sv
// VPU operand fetch controller: accepts a decoded instruction, reads up to
// N_PORTS operands in parallel from SRAM ports and hands the operand bundle
// to the ALU stage. Optional watchdog enabled by `define VPU_FETCH_TIMEOUT_EN.
module vpu_operand_fetch_ctrl
  import vpu_operand_fetch_ctrl_pkg::*;
#(
  parameter int N_PORTS     = N_PORTS_DEF,
  parameter int OPCODE_W    = OPCODE_W_DEF,
  parameter int BANK_LG2    = BANK_LG2_DEF,
  parameter int DEPTH_LG2   = DEPTH_LG2_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  vpu_operand_fetch_ctrl_if.slave  bus
);

  localparam int ADDR_W = BANK_LG2 + DEPTH_LG2;

  fetch_state_t                state;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic                        busy_q;
  logic                        timeout_err_q;
  logic [OPCODE_W-1:0]         opcode_q;
  logic [ADDR_W-1:0]           waddr_q;
  logic [N_PORTS-1:0]          rmask_q;
  logic [N_PORTS*ADDR_W-1:0]   raddr_q;

  logic [N_PORTS-1:0]          req;
  logic [N_PORTS-1:0]          outstanding;
  logic [N_PORTS-1:0]          got;
  logic [N_PORTS-1:0]          got_nxt;
  logic [N_PORTS*DATA_W-1:0]   operand;

  logic accept;
  logic release_out;
  logic all_acked;
  logic done;
  logic timeout_hit;

  assign accept      = (state == ST_IDLE) && bus.in_valid;
  assign release_out = (state == ST_OUT) && bus.out_ready;
  // Looking at this cycle's captures lets the last rvalid move straight to OUT.
  assign got_nxt     = got | (outstanding & bus.src_rvalid);
  assign done        = (got_nxt == rmask_q);
  assign all_acked   = (((outstanding | got) & rmask_q) == rmask_q);

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    vpu_fetch_port_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .load_req    (bus.in_rmask[i]),
      .clr         (release_out | timeout_hit),
      .ack         (bus.src_ack[i]),
      .rvalid      (bus.src_rvalid[i]),
      .rdata       (bus.src_rdata[i*DATA_W +: DATA_W]),
      .req         (req[i]),
      .outstanding (outstanding[i]),
      .got         (got[i]),
      .data        (operand[i*DATA_W +: DATA_W])
    );
    assign bus.src_rid[i*BANK_LG2 +: BANK_LG2]    = raddr_q[i*ADDR_W + DEPTH_LG2 +: BANK_LG2];
    assign bus.src_addr[i*DEPTH_LG2 +: DEPTH_LG2] = raddr_q[i*ADDR_W +: DEPTH_LG2];
  end

`ifdef VPU_FETCH_TIMEOUT_EN
  localparam int CNT_W = cnt_w(TIMEOUT_CYC);
  logic [CNT_W-1:0] wd_cnt;

  assign timeout_hit = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !done;

  // Watchdog: counts fetch cycles from entry to ISSUE; error flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (accept)
        wd_cnt <= '0;
      else if ((state == ST_ISSUE) || (state == ST_WAIT))
        wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit)
        timeout_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timeout_err_q      = 1'b0;
`endif

  // Instruction FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      opcode_q    <= '0;
      waddr_q     <= '0;
      rmask_q     <= '0;
      raddr_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            opcode_q   <= bus.in_opcode;
            waddr_q    <= bus.in_waddr;
            rmask_q    <= bus.in_rmask;
            raddr_q    <= bus.in_raddr;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.in_rmask != '0) begin
              state <= ST_ISSUE;
            end else begin
              state       <= ST_OUT;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (done || timeout_hit) begin
            state       <= ST_OUT;
            out_valid_q <= 1'b1;
          end else if (all_acked) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done || timeout_hit) begin
            state       <= ST_OUT;
            out_valid_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.src_req     = req;
  assign bus.src_reb     = ~req;
  assign bus.src_rlast   = req;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_waddr   = waddr_q;
  assign bus.out_operand = operand;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/vpu_operand_fetch_ctrl.md
Name: vpu_operand_fetch_ctrl

Overview:
Sequences operand reads for one VPU instruction. Accepts a decoded request (opcode, per-port read mask, operand addresses, write address) and issues single-beat req/ack reads on up to N SRAM source ports in parallel. It collects the returned rdata and presents the full operand set to the execution stage with valid/ready. Sits between the instruction decoder (REQ_IF producer) and the VPU ALU input stage.

Parameters:
N_PORTS, 3, number of SRAM read ports (matches SRAM_R_PORT_CNT)
OPCODE_W, 8, opcode width
BANK_LG2, 5, bank-id width; operand address MSBs
DEPTH_LG2, 10, bank row-address width; operand address LSBs
DATA_W, 512, SRAM data width
TIMEOUT_CYC, 64, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_opcode  in  OPCODE_W  opcode
in_rmask  in  N_PORTS  bit i = port i operand needed
in_raddr  in  N_PORTS*(BANK_LG2+DEPTH_LG2)  per-port address, {bank, row}, port 0 in LSBs
in_waddr  in  BANK_LG2+DEPTH_LG2  destination address, passed through
src_req  out  N_PORTS  per-port read request
src_ack  in  N_PORTS  per-port grant
src_rid  out  N_PORTS*BANK_LG2  bank id
src_addr  out  N_PORTS*DEPTH_LG2  row address
src_reb  out  N_PORTS  read enable, active-low; 0 while req=1
src_rlast  out  N_PORTS  1 while req=1 (single beat)
src_rdata  in  N_PORTS*DATA_W  read data
src_rvalid  in  N_PORTS  read data valid
out_valid  out  1  operand bundle valid
out_ready  in  1  consumer ready
out_opcode  out  OPCODE_W  latched opcode
out_waddr  out  BANK_LG2+DEPTH_LG2  latched write address
out_operand  out  N_PORTS*DATA_W  captured operands; unmasked ports 0
busy  out  1  state != IDLE
timeout_err  out  1  watchdog flag (0 without macro)

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=1 and src_reb all 1. Outstanding/got flags cleared. Reset mid-operation abandons the instruction, and later rvalid pulses are ignored.
- FSM IDLE -> ISSUE -> WAIT -> OUT -> IDLE.
- IDLE: in_ready=1. On accept, latch all inputs. If in_rmask!=0 go to ISSUE, else go to OUT.
- ISSUE: src_req[i]=1 for each masked port not yet acked; rid/addr come from registers. On src_ack[i], drop req[i] next cycle and set outstanding[i]. Ports are independent and acks may arrive in any order or cycle. Go to WAIT when every masked port is acked.
- req is registered, so the first req appears the cycle after accept.
- Capture (ISSUE or WAIT): src_rvalid[i] with outstanding[i] stores rdata[i] and sets got[i]. rvalid without outstanding, including the ack cycle itself, is ignored. Protocol guarantees rvalid at least 1 cycle after ack.
- WAIT -> OUT when got == rmask.
- OUT: out_valid=1 with stable outputs until out_ready. On handshake, clear flags and go to IDLE. in_ready is 0 in all states except IDLE, so there is no overlap.
- Minimum latency with 0-cycle ack and 1-cycle rvalid: accept at T, req at T+1, rvalid at T+2, out_valid at T+3. With rmask=0, out_valid at T+1.

Optional Feature:
VPU_FETCH_TIMEOUT_EN: a counter runs in ISSUE/WAIT and resets on entry to ISSUE. At TIMEOUT_CYC it sets timeout_err (sticky until rst), forces out_valid with missing operands zeroed, and goes to OUT. Without the macro there is no counter, timeout_err is tied 0, and the block waits indefinitely.

Decomposition:
- VPU_PKG holds the fetch_state_t enum, the operand address struct {bank, row}, and defaults for N_PORTS/widths.
- One sub-module, vpu_fetch_port_slot, instanced per port: req/outstanding/got flags and the data register.
- The top level keeps the FSM, the mask compare and the watchdog.

Test Plan:
1. rmask=001, raddr0={bank 3, row 0x12}, ack same cycle, rvalid 5 cycles later -> rid=3, addr=0x12, reb=0, rlast=1 for one cycle; out_operand[0]=rdata; out_valid once.
2. rmask=111, acks at cycles 2/0/4 and rvalids in reverse order -> each req drops after its own ack; out_valid only after the third rvalid; operands on the correct lanes.
3. rmask=000, opcode=0x5 -> no req; out_valid the cycle after accept; operands 0; opcode 0x5.
4. out_ready held low 10 cycles in OUT -> outputs stable, in_ready=0, new in_valid not accepted; release -> IDLE next cycle.
5. rst pulsed during WAIT, then stale rvalid -> all outputs at reset values, stale rvalid ignored; next request completes normally.
6. With VPU_FETCH_TIMEOUT_EN and TIMEOUT_CYC=8, ack given and no rvalid -> timeout_err=1 after 8 cycles; out_valid with operand 0.
